// File: rtl/handler_tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handler_tap_pkg
// Description : Shared constants and types for the handler tap. These are the
//               AM header bit positions and the tap state encoding. The
//               handler wrapper uses the same constants.
// Revision    : 1.0 - initial release
// ============================================================================
package handler_tap_pkg;

    localparam int DATA_W     = 64;

    // Bit positions of the AM header fields.
    localparam int HANDLER_HI = 59;
    localparam int HANDLER_LO = 56;
    localparam int DEST_HI    = 39;
    localparam int DEST_LO    = 24;

    // Tap state: header beat, handler argument beats, remaining body beats.
    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_ARGS   = 2'd1,
        ST_BODY   = 2'd2
    } state_t;

    // Returns the handler id field of a header beat.
    function automatic logic [HANDLER_HI-HANDLER_LO:0] get_handler_id(
        input logic [DATA_W-1:0] hdr
    );
        return hdr[HANDLER_HI:HANDLER_LO];
    endfunction

    // Returns the destination field of a header beat.
    function automatic logic [DEST_HI-DEST_LO:0] get_dest(
        input logic [DATA_W-1:0] hdr
    );
        return hdr[DEST_HI:DEST_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/handler_tap_if.sv
`default_nettype none
// ============================================================================
// Module      : handler_tap_if
// Description : AXI-Stream bundle of 64-bit data, tlast, tvalid and tready.
//               The master drives the data and tvalid. The slave drives
//               tready.
// Revision    : 1.0 - initial release
// ============================================================================
interface handler_tap_if;
    import handler_tap_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/handler_tap_axis_broadcast_flags.sv
`default_nettype none
// ============================================================================
// Module      : axis_broadcast_flags
// Description : Broadcasts one input stream to two output branches with
//               zero latency. Each branch has a sticky done flag. The flag
//               records that the branch has already taken the current beat,
//               so the branch sees that beat only once while the other branch
//               stalls. Branch tvalid never depends on tready.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_broadcast_flags (
    input  wire logic i_clock,
    input  wire logic i_reset_n,
    input  wire logic i_in_tvalid,
    input  wire logic i_copy_active,
    input  wire logic i_main_tready,
    input  wire logic i_hdl_tready,
    output logic      o_in_tready,
    output logic      o_main_tvalid,
    output logic      o_hdl_tvalid
);

    logic r_main_done;
    logic r_hdl_done;
    logic w_in_accept;

    assign o_main_tvalid = i_in_tvalid & ~r_main_done;
    assign o_hdl_tvalid  = i_in_tvalid & i_copy_active & ~r_hdl_done;
    assign o_in_tready   = (r_main_done | i_main_tready) &
                           (~i_copy_active | r_hdl_done | i_hdl_tready);
    assign w_in_accept   = i_in_tvalid & o_in_tready;

    // Set a branch flag on a branch-only handshake. Clear both flags when the
    // input beat is finally accepted.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_main_done <= 1'b0;
            r_hdl_done  <= 1'b0;
        end else if (w_in_accept) begin
            r_main_done <= 1'b0;
            r_hdl_done  <= 1'b0;
        end else begin
            if (o_main_tvalid && i_main_tready) begin
                r_main_done <= 1'b1;
            end
            if (o_hdl_tvalid && i_hdl_tready) begin
                r_hdl_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/handler_tap.sv
`default_nettype none
// ============================================================================
// Module      : handler_tap
// Description : Taps incoming AM packets.
//               - Every beat is forwarded to the main stream.
//               - For packets whose header has a nonzero handler id, the
//                 header and up to HANDLER_ARGS payload words are also copied
//                 to the handler stream.
//               - Packets sent to the handler are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module handler_tap
    import handler_tap_pkg::*;
#(
    parameter int HANDLER_ARGS = 1
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    handler_tap_if.slave      axis_in,
    handler_tap_if.master     axis_main,
    handler_tap_if.master     axis_handler,
    output logic [31:0]       handler_pkt_count
);

    localparam logic [4:0] c_handler_args = 5'(HANDLER_ARGS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_arg_cnt;
    logic [3:0]  w_arg_cnt_nxt;
    logic        r_copy_en;
    logic        w_copy_en_nxt;
    logic [31:0] r_pkt_count;

    logic        w_in_accept;
    logic        w_in_tready;
    logic        w_hdr_bearing;
    logic        w_copy_en;
    logic        w_copy_active;
    logic [4:0]  w_arg_cnt_inc;
    logic        w_hdr_is_last_arg;

    assign w_hdr_bearing = (get_handler_id(axis_in.tdata) != '0);
    assign w_copy_en     = (r_state == ST_HEADER) ? w_hdr_bearing : r_copy_en;
    assign w_copy_active = w_copy_en &&
                           ((r_state == ST_HEADER) || (r_state == ST_ARGS));
    assign w_in_accept   = axis_in.tvalid & w_in_tready;
    assign w_arg_cnt_inc = {1'b0, r_arg_cnt} + 5'd1;

    // With no arguments configured, the header is the last handler beat.
    if (HANDLER_ARGS == 0) begin : g_no_args
        assign w_hdr_is_last_arg = 1'b1;
    end else begin : g_with_args
        assign w_hdr_is_last_arg = 1'b0;
    end

    axis_broadcast_flags u_flags (
        .i_clock       (clock),
        .i_reset_n     (reset_n),
        .i_in_tvalid   (axis_in.tvalid),
        .i_copy_active (w_copy_active),
        .i_main_tready (axis_main.tready),
        .i_hdl_tready  (axis_handler.tready),
        .o_in_tready   (w_in_tready),
        .o_main_tvalid (axis_main.tvalid),
        .o_hdl_tvalid  (axis_handler.tvalid)
    );

    assign axis_in.tready     = w_in_tready;
    assign axis_main.tdata    = axis_in.tdata;
    assign axis_main.tlast    = axis_in.tlast;
    assign axis_handler.tdata = axis_in.tdata;
    assign axis_handler.tlast = axis_in.tlast ||
                                ((r_state == ST_HEADER) && w_hdr_is_last_arg) ||
                                ((r_state == ST_ARGS) &&
                                 (w_arg_cnt_inc == c_handler_args));
    assign handler_pkt_count  = r_pkt_count;

    // State, argument counter and copy-enable registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= ST_HEADER;
            r_arg_cnt <= 4'd0;
            r_copy_en <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_arg_cnt <= w_arg_cnt_nxt;
            r_copy_en <= w_copy_en_nxt;
        end
    end

    // Next-state logic. The tap advances only on accepted input beats.
    always_comb begin
        w_state_nxt   = r_state;
        w_arg_cnt_nxt = r_arg_cnt;
        w_copy_en_nxt = r_copy_en;
        case (r_state)
            ST_HEADER: begin
                if (w_in_accept) begin
                    w_copy_en_nxt = w_hdr_bearing;
                    w_arg_cnt_nxt = 4'd0;
                    if (axis_in.tlast) begin
                        w_state_nxt = ST_HEADER;
                    end else if (w_hdr_bearing && (c_handler_args != 5'd0)) begin
                        w_state_nxt = ST_ARGS;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_ARGS: begin
                if (w_in_accept) begin
                    w_arg_cnt_nxt = w_arg_cnt_inc[3:0];
                    if (axis_in.tlast) begin
                        w_state_nxt = ST_HEADER;
                    end else if (w_arg_cnt_inc == c_handler_args) begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (w_in_accept && axis_in.tlast) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            default: begin
                w_state_nxt = ST_HEADER;
            end
        endcase
    end

    // Count accepted handler-bearing headers. The count saturates at all-ones.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pkt_count <= 32'd0;
        end else if (w_in_accept && (r_state == ST_HEADER) && w_hdr_bearing &&
                     (r_pkt_count != 32'hFFFF_FFFF)) begin
            r_pkt_count <= r_pkt_count + 32'd1;
        end
    end

endmodule
`default_nettype wire
